// File: rtl/fetch_unit.sv
// Program-counter sequencer feeding the instruction ROM: increments, redirects,
// stalls and parks on HALT, with a saturating retired-instruction counter.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] target,
  input  logic        halt_op,
  output logic [15:0] pc,
  output logic        fetch_valid,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_nxt;
  logic [15:0] count_nxt;
  logic [15:0] count_inc;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign count_inc = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_count <= count_nxt;
    end
  end

  // NOTE: every output of this block is given a hold default before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = instr_count;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (stall) begin
          // Nothing retires; redirect and halt_op wait for an unstalled edge.
        end else if (halt_op) begin
          state_nxt = HALT;
          count_nxt = count_inc;
        end else if (redirect) begin
          // target is only muxed in here, so an X elsewhere never reaches pc.
          pc_nxt    = target;
          count_nxt = count_inc;
        end else begin
          pc_nxt    = pc + 16'd1;
          count_nxt = count_inc;
        end
      end
      HALT: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = RESET_PC;
          count_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the sequencing rules.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, redirect, halt_op;
  logic [15:0] target;
  logic [15:0] pc, instr_count;
  logic        fetch_valid, halted;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: running/parked flags, current pc, unbounded count.
  bit          m_run, m_halt;
  logic [15:0] m_pc;
  int          m_cnt;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .redirect    (redirect),
    .target      (target),
    .halt_op     (halt_op),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat_cnt();
    return (m_cnt > 65535) ? 16'hFFFF : m_cnt[15:0];
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_halt = 1'b0;
    m_pc   = RESET_PC;
    m_cnt  = 0;
  endtask

  // One clock edge worth of architectural behaviour.
  task automatic model_step();
    if (!m_run && !m_halt) begin
      if (start) m_run = 1'b1;
    end else if (m_halt) begin
      if (start) begin
        m_halt = 1'b0;
        m_run  = 1'b1;
        m_pc   = RESET_PC;
        m_cnt  = 0;
      end
    end else if (!stall) begin
      m_cnt = m_cnt + 1;
      if (halt_op) begin
        m_run  = 1'b0;
        m_halt = 1'b1;
      end else if (redirect) begin
        m_pc = target;
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("fetch_valid", {15'd0, fetch_valid}, {15'd0, m_run});
      check("halted", {15'd0, halted}, {15'd0, m_halt});
      check("instr_count", instr_count, sat_cnt());
    end
  end

  task automatic cycle(input logic s, input logic st, input logic r,
                       input logic [15:0] t, input logic h);
    start = s; stall = st; redirect = r; target = t; halt_op = h;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    start = 0; stall = 0; redirect = 0; target = 'x; halt_op = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("reset_pc", pc, 16'd0);
    check("reset_count", instr_count, 16'd0);
    check("reset_flags", {14'd0, fetch_valid, halted}, 16'd0);

    // IDLE ignores everything but start, including an X target.
    cycle(0, 0, 1, 'x, 1);
    check("idle_hold_pc", pc, 16'd0);

    // Sequential run.
    cycle(1, 0, 0, 'x, 0);
    check("start_valid", {15'd0, fetch_valid}, 16'd1);
    check("start_pc", pc, 16'd0);
    repeat (5) cycle(0, 0, 0, 'x, 0);
    check("seq_pc", pc, 16'd5);
    check("seq_count", instr_count, 16'd5);

    // Redirect, then halt_op beating redirect.
    cycle(0, 0, 1, 16'd10, 0);
    cycle(0, 0, 1, 16'd3, 0);
    check("redir_pc", pc, 16'd3);
    check("redir_count", instr_count, 16'd7);
    cycle(0, 0, 1, 16'd40, 1);
    check("halt_prio_pc", pc, 16'd3);
    check("halt_prio_flag", {15'd0, halted}, 16'd1);
    check("halt_prio_count", instr_count, 16'd8);

    // Restart, stall with pending redirect, stall with pending halt.
    cycle(1, 0, 0, 'x, 0);
    check("restart_count", instr_count, 16'd0);
    cycle(0, 0, 1, 16'd7, 0);
    repeat (3) cycle(0, 1, 1, 16'd20, 0);
    check("stall_pc", pc, 16'd7);
    check("stall_count", instr_count, 16'd1);
    cycle(0, 1, 1, 16'd20, 1);
    check("stall_halt", {15'd0, halted}, 16'd0);
    cycle(0, 0, 1, 16'd20, 0);
    check("unstall_pc", pc, 16'd20);

    // Halt and restart.
    cycle(0, 0, 1, 16'd25, 0);
    cycle(0, 0, 0, 'x, 1);
    check("halt_pc", pc, 16'd25);
    check("halt_valid", {15'd0, fetch_valid}, 16'd0);
    cycle(0, 0, 1, 16'd99, 0);
    check("halted_redir_pc", pc, 16'd25);
    cycle(1, 1, 0, 'x, 0);
    check("restart_pc", pc, RESET_PC);
    check("restart_valid", {15'd0, fetch_valid}, 16'd1);

    // PC wrap.
    cycle(0, 0, 1, 16'hFFFE, 0);
    cycle(0, 0, 0, 'x, 0);
    check("wrap_ffff", pc, 16'hFFFF);
    cycle(0, 0, 0, 'x, 0);
    check("wrap_0000", pc, 16'h0000);
    cycle(0, 0, 0, 'x, 0);
    check("wrap_0001", pc, 16'h0001);

    // Random traffic, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = ($urandom_range(0, 3) == 0);
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, r,
            r ? 16'($urandom) : 16'hxxxx, $urandom_range(0, 15) == 0);
    end

    // Counter saturation: retire well past 0xFFFF instructions.
    do_reset();
    cycle(1, 0, 0, 'x, 0);
    for (int i = 0; i < 65537; i++) cycle(0, 0, $urandom_range(0, 7) == 0, 16'($urandom), 0);
    check("sat_count", instr_count, 16'hFFFF);
    cycle(0, 0, 0, 'x, 0);
    check("sat_hold", instr_count, 16'hFFFF);

    // Asynchronous reset between edges.
    cycle(0, 0, 1, 16'd14, 0);
    check("pre_areset_pc", pc, 16'd14);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("areset_pc", pc, 16'd0);
    check("areset_count", instr_count, 16'd0);
    check("areset_flags", {14'd0, fetch_valid, halted}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(0, 0, 1, 16'd50, 0);
    check("post_areset_pc", pc, 16'd0);
    check("post_areset_valid", {15'd0, fetch_valid}, 16'd0);
    cycle(1, 0, 0, 'x, 0);
    check("post_areset_start", {15'd0, fetch_valid}, 16'd1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter sequencer that sits directly upstream of the instruction ROM/decoder. Each cycle it drives the 16-bit `pc` that the ROM decodes combinationally, and it advances that PC. The PC increments by default, takes a jump/branch target when redirected, holds on stall, and parks on a HALT instruction. It also keeps a retired-instruction count for bench and debug use.

## Interface
- `RESET_PC`, default 16'd0: PC value loaded on reset and on restart.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse. Leaves IDLE, or restarts from HALT.
- `stall`  in  1  downstream cannot retire the instruction at `pc`. Hold everything.
- `redirect`  in  1  the instruction at `pc` is a taken JMP or branch.
- `target`  in  16  redirect destination (the decoder's `jmpLoc`).
- `halt_op`  in  1  the decoder reports opcode 4'b1110 (HALT) at the current `pc`.
- `pc`  out  16  current fetch address, feeding the ROM `pc` input.
- `fetch_valid`  out  1  `pc` holds a live instruction (state RUN).
- `halted`  out  1  a HALT instruction has retired (state HALT).
- `instr_count`  out  16  number of retired instructions, saturating.

## Operation
- Three states: IDLE, RUN, HALT. All outputs are registered or decoded from state only (Moore).
- Reset, asynchronous, effective immediately, from any state including mid-run:
  - state = IDLE
  - `pc` = RESET_PC
  - `fetch_valid` = 0, `halted` = 0
  - `instr_count` = 0
- IDLE:
  - `start` = 1 moves to RUN. `pc` is unchanged (RESET_PC) and `instr_count` is unchanged.
  - All other inputs are ignored.
- RUN: `fetch_valid` = 1. Each edge applies the first matching rule below.
  1. `stall` = 1: `pc` and `instr_count` hold. `redirect` and `halt_op` are ignored this cycle.
  2. `halt_op` = 1: go to HALT, `pc` holds (still points at the HALT instruction), `instr_count` += 1. `halt_op` wins over `redirect`.
  3. `redirect` = 1: `pc` = `target`, `instr_count` += 1.
  4. Otherwise: `pc` = `pc` + 1, `instr_count` += 1.
  - `start` is ignored in RUN.
- HALT: `halted` = 1, `fetch_valid` = 0. `pc` and `instr_count` hold.
  - `start` = 1 moves to RUN with `pc` = RESET_PC and `instr_count` = 0.
  - `stall`, `redirect` and `halt_op` are ignored.
- Arithmetic:
  - `pc` + 1 is modulo 2^16, so 16'hFFFF wraps to 16'h0000 with no flag.
  - `target` is taken verbatim as 16 bits, with no range check.
  - `instr_count` saturates at 16'hFFFF and never wraps.
- X handling: `target` is don't-care unless `redirect` = 1 in RUN and unstalled. An X on `target` at any other time must not propagate into `pc`.

## Timing
- `pc` is a register. ROM decode outputs, and therefore `redirect`, `target` and `halt_op`, are combinational from `pc` in the same cycle.
- Control inputs are sampled on the rising edge. The new `pc` appears the following cycle.
- Throughput and penalties:
  - One instruction per cycle when unstalled.
  - Zero-bubble jump and branch: `target` is the very next `pc`.
- Latency from the `start` edge to the first cycle with `fetch_valid` = 1 is one cycle.
- `halted` rises in the cycle after the HALT instruction's edge. `fetch_valid` falls in that same cycle.
- When `stall` and `halt_op` are both high, the HALT does not retire until the first unstalled edge.
- `rst_n` is deasserted synchronously to `clk` by the system. The block needs no internal synchronizer.

## Test plan
- **Sequential run.** Reset, pulse `start`, hold `redirect`/`halt_op`/`stall` at 0 for 5 cycles -> `pc` = 0, 1, 2, 3, 4, 5 and `instr_count` = 5; `fetch_valid` = 1 from cycle 1.
- **Redirect and priority.**
  - At `pc` = 10, assert `redirect` with `target` = 16'd3 -> next `pc` = 3, `instr_count` increments once.
  - Then assert `redirect` and `halt_op` together -> HALT is entered and `pc` holds at 3.
- **Stall.**
  - At `pc` = 7, hold `stall` for 3 cycles while `redirect` = 1 and `target` = 20 -> `pc` stays 7 and `instr_count` is frozen.
  - Release `stall` -> `pc` = 20.
- **Halt and restart.**
  - `halt_op` at `pc` = 25 -> `halted` = 1, `fetch_valid` = 0, `pc` = 25, counter frozen.
  - `redirect` while halted has no effect.
  - Pulse `start` -> `pc` = RESET_PC, `instr_count` = 0, `fetch_valid` = 1.
- **Wrap and saturate.**
  - `redirect` to 16'hFFFE, then run 3 cycles -> `pc` = FFFF, 0000, 0001.
  - Force `instr_count` to FFFE, then retire 3 instructions -> `instr_count` = FFFF and stays there.
- **Async reset mid-run.** Drop `rst_n` between edges while `pc` = 14 -> `pc` = 0, IDLE, and all flags go to 0 immediately without waiting for a clock edge. After `rst_n` releases, no advance occurs until `start`.
